// File: rtl/spi_rx.sv
// SPI receive front end: synchronises an external SPI bus clock and data line into the
// clk domain, shifts in a frame LSB first and hands the word over a valid/ready port.
`timescale 1ns/1ps
module spi_rx #(
   parameter int unsigned DLY            = 1,
   parameter int unsigned SPI_RX_WIDTH   = 32,
   parameter int unsigned LENGTH_RECEIVE = $clog2(SPI_RX_WIDTH),
   parameter int unsigned TIMEOUT        = 64
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      cpol,
   input  logic                      cpoa,
   input  logic [LENGTH_RECEIVE:0]   length,
   input  logic                      sdi,
   input  logic                      spi_bus_clk,
   output logic [SPI_RX_WIDTH-1:0]   rx_data,
   output logic                      rx_vld,
   input  logic                      rx_rdy,
   output logic                      rx_busy,
   output logic                      rx_ovf,
   output logic                      rx_err
);

   localparam int unsigned LW = LENGTH_RECEIVE + 1;
   localparam int unsigned IW = $clog2(TIMEOUT + 1);
   localparam logic [LW-1:0] WidthL   = LW'(SPI_RX_WIDTH);
   localparam logic [IW-1:0] TimeoutL = IW'(TIMEOUT - 1);

   typedef enum logic [0:0] {RX_IDLE, RX_RECV} state_e;

   // DLY only models register delay in legacy simulation; synthesis sees zero delay.
   logic unused_dly;
   assign unused_dly = ^DLY;

   logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
   logic sdi_s1_q, sdi_s2_q;
   logic rise, fall, sample;

   state_e                  state_q;
   logic [LW-1:0]           bit_cnt_q;
   logic [LW-1:0]           frame_len_q;
   logic [IW-1:0]           idle_cnt_q;
   logic [SPI_RX_WIDTH-1:0] shift_q;
   logic [SPI_RX_WIDTH-1:0] shift_set;
   logic [SPI_RX_WIDTH-1:0] done_word_q;
   logic                    done_q;
   logic                    busy_q;
   logic                    err_q;

   logic [SPI_RX_WIDTH-1:0] rx_data_q;
   logic                    rx_vld_q;
   logic                    rx_ovf_q;

   // Two-flop synchronisers; a third bus-clock stage gives the edge detector its history.
   // Flops reset to the idle bus level so no edge is seen until the bus really toggles.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bclk_s1_q <= cpol;
         bclk_s2_q <= cpol;
         bclk_s3_q <= cpol;
         sdi_s1_q  <= cpol;
         sdi_s2_q  <= cpol;
      end else begin
         bclk_s1_q <= spi_bus_clk;
         bclk_s2_q <= bclk_s1_q;
         bclk_s3_q <= bclk_s2_q;
         sdi_s1_q  <= sdi;
         sdi_s2_q  <= sdi_s1_q;
      end
   end

   // sdi_s2_q has the same latency as bclk_s2_q, the stage that reveals the edge.
   assign rise   = bclk_s2_q & ~bclk_s3_q;
   assign fall   = ~bclk_s2_q & bclk_s3_q;
   assign sample = (cpol == cpoa) ? rise : fall;

   // Shift register with the current sample written at position bit_cnt.
   always_comb begin
      shift_set = shift_q;
      for (int i = 0; i < SPI_RX_WIDTH; i++) begin
         if (bit_cnt_q == LW'(i)) shift_set[i] = sdi_s2_q;
      end
   end

   // Receive FSM: frame start, bit shifting, completion and idle timeout.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= RX_IDLE;
         bit_cnt_q   <= '0;
         frame_len_q <= '0;
         idle_cnt_q  <= '0;
         shift_q     <= '0;
         done_word_q <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            RX_IDLE: begin
               if (sample && (length != '0)) begin
                  frame_len_q <= (length > WidthL) ? WidthL : length;
                  shift_q     <= {{(SPI_RX_WIDTH-1){1'b0}}, sdi_s2_q};
                  bit_cnt_q   <= LW'(1);
                  idle_cnt_q  <= '0;
                  state_q     <= RX_RECV;
                  busy_q      <= 1'b1;
               end
            end
            RX_RECV: begin
               if (bit_cnt_q == frame_len_q) begin
                  done_word_q <= shift_q;
                  done_q      <= 1'b1;
                  shift_q     <= '0;
                  bit_cnt_q   <= '0;
                  idle_cnt_q  <= '0;
                  state_q     <= RX_IDLE;
                  busy_q      <= 1'b0;
               end else if (sample) begin
                  shift_q    <= shift_set;
                  bit_cnt_q  <= bit_cnt_q + LW'(1);
                  idle_cnt_q <= '0;
               end else if (idle_cnt_q == TimeoutL) begin
                  // Bus went quiet mid-frame: drop the partial word.
                  err_q      <= 1'b1;
                  shift_q    <= '0;
                  bit_cnt_q  <= '0;
                  idle_cnt_q <= '0;
                  state_q    <= RX_IDLE;
                  busy_q     <= 1'b0;
               end else begin
                  idle_cnt_q <= idle_cnt_q + IW'(1);
               end
            end
            default: begin
               state_q <= RX_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Output handshake: load a completed word unless an unaccepted one is still held.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_data_q <= '0;
         rx_vld_q  <= 1'b0;
         rx_ovf_q  <= 1'b0;
      end else begin
         rx_ovf_q <= 1'b0;
         if (done_q) begin
            if (!rx_vld_q || rx_rdy) begin
               rx_data_q <= done_word_q;
               rx_vld_q  <= 1'b1;
            end else begin
               rx_ovf_q <= 1'b1;
            end
         end else if (rx_vld_q && rx_rdy) begin
            rx_vld_q <= 1'b0;
         end
      end
   end

   assign rx_data = rx_data_q;
   assign rx_vld  = rx_vld_q;
   assign rx_ovf  = rx_ovf_q;
   assign rx_err  = err_q;
   assign rx_busy = busy_q;

endmodule

// File: tb/tb_spi_rx.sv
// Directed bench for spi_rx: bit-banged SPI frames, scoreboard of expected words popped on
// each accepted transfer, plus pulse/latency counters sampled on the falling clk edge.
`timescale 1ns/1ps
module tb_spi_rx;

   localparam int H = 5;  // bus half-period in clk cycles

   logic        clk;
   logic        rstn;
   logic        cpol;
   logic        cpoa;
   logic [5:0]  length;
   logic        sdi;
   logic        spi_bus_clk;
   logic [31:0] rx_data;
   logic        rx_vld;
   logic        rx_rdy;
   logic        rx_busy;
   logic        rx_ovf;
   logic        rx_err;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_word;
   int   vld_cyc  = 0;
   int   ovf_cyc  = 0;
   int   err_cyc  = 0;
   int   busy_cyc = 0;
   logic vld_prev = 1'b0;
   logic seen34   = 1'b0;
   time  vld_rise_t  = 0;
   time  last_edge_t = 0;

   spi_rx dut (
      .clk         (clk),
      .rstn        (rstn),
      .cpol        (cpol),
      .cpoa        (cpoa),
      .length      (length),
      .sdi         (sdi),
      .spi_bus_clk (spi_bus_clk),
      .rx_data     (rx_data),
      .rx_vld      (rx_vld),
      .rx_rdy      (rx_rdy),
      .rx_busy     (rx_busy),
      .rx_ovf      (rx_ovf),
      .rx_err      (rx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive nbits of data LSB first in the current cpol/cpoa mode.
   task automatic send_bits(input logic [31:0] data, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         if (!cpoa) begin
            sdi = data[i];
            wait_clk(H);
            spi_bus_clk = ~cpol;
            last_edge_t = $time;
            wait_clk(H);
            spi_bus_clk = cpol;
         end else begin
            spi_bus_clk = ~cpol;
            sdi = data[i];
            wait_clk(H);
            spi_bus_clk = cpol;
            last_edge_t = $time;
            wait_clk(H);
         end
      end
   endtask

   // Change mode with length=0 so any bus-level adjustment cannot start a frame.
   task automatic set_mode(input logic pol, input logic pha, input logic [5:0] len);
      length = '0;
      cpol   = pol;
      cpoa   = pha;
      wait_clk(2);
      spi_bus_clk = pol;
      wait_clk(8);
      length = len;
   endtask

   // Monitor: pulse counters and scoreboard pop on every accepted word.
   always @(negedge clk) begin
      if (rx_vld && !vld_prev) vld_rise_t = $time;
      vld_prev = rx_vld;
      if (rx_vld)  vld_cyc++;
      if (rx_ovf)  ovf_cyc++;
      if (rx_err)  err_cyc++;
      if (rx_busy) busy_cyc++;
      if (rx_data == 32'h34) seen34 = 1'b1;
      if (rstn && rx_vld && rx_rdy) begin
         check("sb_expected_present", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            exp_word = exp_q.pop_front();
            check("sb_word", 64'(rx_data), 64'(exp_word));
         end
      end
   end

   int vld0, ovf0, err0, busy0;

   initial begin
      rstn = 1'b0; cpol = 1'b0; cpoa = 1'b0; length = 6'd8;
      sdi = 1'b0; spi_bus_clk = 1'b0; rx_rdy = 1'b1;
      wait_clk(3);
      check("rst_data", 64'(rx_data), 64'd0);
      check("rst_vld",  64'(rx_vld),  64'd0);
      check("rst_busy", 64'(rx_busy), 64'd0);
      check("rst_ovf",  64'(rx_ovf),  64'd0);
      check("rst_err",  64'(rx_err),  64'd0);
      rstn = 1'b1;
      wait_clk(5);
      check("no_edge_after_rst", 64'(rx_busy), 64'd0);

      // Mode 0, 8-bit 0xA5
      vld0 = vld_cyc;
      exp_q.push_back(32'h0000_00A5);
      send_bits(32'hA5, 8);
      wait_clk(20);
      check("latency_5clk", 64'(vld_rise_t - last_edge_t), 64'd50);
      check("vld_one_cycle", 64'(vld_cyc - vld0), 64'd1);
      check("busy_low_after", 64'(rx_busy), 64'd0);
      check("vld_low_after", 64'(rx_vld), 64'd0);

      // All four modes, 32-bit 0xDEADBEEF
      for (int m = 0; m < 4; m++) begin
         set_mode(m[1], m[0], 6'd32);
         exp_q.push_back(32'hDEAD_BEEF);
         send_bits(32'hDEAD_BEEF, 32);
         wait_clk(20);
      end
      check("modes_all_popped", 64'(exp_q.size()), 64'd0);
      set_mode(1'b0, 1'b0, 6'd8);

      // Overflow: consumer stalled, second frame dropped
      @(posedge clk); #1 rx_rdy = 1'b0;
      ovf0 = ovf_cyc;
      seen34 = 1'b0;
      send_bits(32'h12, 8);
      wait_clk(20);
      check("ovf_first_held", 64'(rx_data), 64'h12);
      send_bits(32'h34, 8);
      wait_clk(20);
      check("ovf_data_kept", 64'(rx_data), 64'h12);
      check("ovf_vld_kept", 64'(rx_vld), 64'd1);
      check("ovf_one_pulse", 64'(ovf_cyc - ovf0), 64'd1);
      check("ovf_0x34_never", 64'(seen34), 64'd0);
      exp_q.push_back(32'h12);
      @(posedge clk); #1 rx_rdy = 1'b1;
      wait_clk(4);
      check("accept_clears_vld", 64'(rx_vld), 64'd0);
      check("accept_data_holds", 64'(rx_data), 64'h12);

      // Timeout: 5 bits of a 16-bit frame then silence
      length = 6'd16;
      err0 = err_cyc;
      vld0 = vld_cyc;
      send_bits(32'hFFFF, 5);
      wait_clk(100);
      check("timeout_err_once", 64'(err_cyc - err0), 64'd1);
      check("timeout_no_vld", 64'(vld_cyc - vld0), 64'd0);
      check("timeout_idle", 64'(rx_busy), 64'd0);
      exp_q.push_back(32'h0000_BEEF);
      send_bits(32'hBEEF, 16);
      wait_clk(20);
      check("after_timeout_data", 64'(rx_data), 64'h0000_BEEF);

      // Reset mid-frame after 3 bits
      length = 6'd8;
      send_bits(32'h5A, 3);
      check("midframe_busy", 64'(rx_busy), 64'd1);
      rstn = 1'b0;
      #1;
      check("mid_rst_data", 64'(rx_data), 64'd0);
      check("mid_rst_vld",  64'(rx_vld),  64'd0);
      check("mid_rst_busy", 64'(rx_busy), 64'd0);
      check("mid_rst_ovf",  64'(rx_ovf),  64'd0);
      check("mid_rst_err",  64'(rx_err),  64'd0);
      wait_clk(3);
      rstn = 1'b1;
      wait_clk(5);
      exp_q.push_back(32'h5A);
      send_bits(32'h5A, 8);
      wait_clk(20);
      check("post_rst_data", 64'(rx_data), 64'h5A);

      // length above width clamps to 32
      length = 6'd40;
      exp_q.push_back(32'hCAFE_F00D);
      send_bits(32'hCAFE_F00D, 32);
      wait_clk(20);
      check("clamp_busy_low", 64'(rx_busy), 64'd0);
      check("clamp_popped", 64'(exp_q.size()), 64'd0);

      // length 0 ignores the bus entirely
      length = 6'd0;
      vld0  = vld_cyc;
      busy0 = busy_cyc;
      send_bits(32'hFF, 8);
      wait_clk(20);
      check("len0_no_vld", 64'(vld_cyc - vld0), 64'd0);
      check("len0_no_busy", 64'(busy_cyc - busy0), 64'd0);

      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
